// File: rtl/wb_core_bridge_pkg.sv
// Shared types and helper functions for the multi-port Wishbone core bridge.
package wb_core_bridge_pkg;

  // Bridge controller states; ST_RESP is only reached when the response is registered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of byte-select lines for a given data width.
  function automatic int unsigned sel_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Width of a port index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/wb_core_bridge_if.sv
// Core-side request/response ports plus the Wishbone classic master signals.
interface wb_core_bridge_if
  import wb_core_bridge_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SEL_W = sel_width(DATA_WIDTH);

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*SEL_W-1:0]      req_sel;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic                            resp_err;
  logic [DATA_WIDTH-1:0]           resp_rdata;

  logic                            core_cyc;
  logic                            core_stb;
  logic                            core_we;
  logic [SEL_W-1:0]                core_sel;
  logic [ADDR_WIDTH-1:0]           core_addr;
  logic [DATA_WIDTH-1:0]           core_data_out;
  logic [DATA_WIDTH-1:0]           core_data_in;
  logic                            core_ack;

  // Bridge view: serves core requests, masters the Wishbone bus.
  modport slave (
    input  req_valid, req_we, req_sel, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
    input  core_data_in, core_ack
  );

  // Environment view: issues requests and plays the Wishbone slave.
  modport master (
    output req_valid, req_we, req_sel, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
    output core_data_in, core_ack
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin grant selection; search starts one past the last accepted port.
module wb_rr_arbiter
  import wb_core_bridge_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_accept,
  output logic [NUM_PORTS-1:0] o_grant_c,
  output logic [IDX_W-1:0]     o_grant_idx_c,
  output logic                 o_any_c
);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  int unsigned      w_cand;

  // First requesting port at or after last+1, wrapping modulo NUM_PORTS.
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      w_cand = (32'(r_last) + 32'd1 + k) % NUM_PORTS;
      if (!w_found && i_req[IDX_W'(w_cand)]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(w_cand);
      end
    end
  end

  assign o_any_c       = w_found;
  assign o_grant_idx_c = w_idx;
  assign o_grant_c     = w_found ? (NUM_PORTS'(1) << w_idx) : '0;

  // Remember the accepted port so it gets lowest priority next round.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IDX_W'(NUM_PORTS - 1);
    end else if (i_accept && w_found) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/wb_core_bridge.sv
// Multi-port core request bridge onto a single Wishbone classic master.
module wb_core_bridge
  import wb_core_bridge_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_RESP       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  wb_core_bridge_if.slave bus
);

  localparam int unsigned SEL_W   = sel_width(DATA_WIDTH);
  localparam int unsigned IDX_W   = idx_width(NUM_PORTS);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e                r_state;
  state_e                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_cyc;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;

  logic [NUM_PORTS-1:0]  w_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_any;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [NUM_PORTS-1:0]  w_resp_onehot;
  logic [NUM_PORTS-1:0]  w_req_ready;

  logic [SEL_W-1:0]      w_sel_arr   [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_PORTS];

  // Split the packed per-port request fields into indexable arrays.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign w_sel_arr[p]   = bus.req_sel[p*SEL_W +: SEL_W];
    assign w_addr_arr[p]  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[p] = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
  end

  wb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .i_req         (bus.req_valid),
    .i_accept      (w_accept),
    .o_grant_c     (w_grant),
    .o_grant_idx_c (w_grant_idx),
    .o_any_c       (w_any)
  );

  // Timeout fires on the TIMEOUT_CYCLES-th bus cycle; zero disables it.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST));

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and transfer control decode.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept = 1'b1;
          w_next   = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus.core_ack || w_timeout) begin
          w_done = 1'b1;
          w_next = (REG_RESP != 0) ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Accept pulse is held off while reset is asserted so outputs stay quiet.
  always_comb begin
    w_req_ready = '0;
    if (w_accept && rst_n) begin
      w_req_ready = w_grant;
    end
  end

  // Ack wins over a coincident timeout; writes and timeouts return zero data.
  assign w_err         = !bus.core_ack;
  assign w_rdata       = (bus.core_ack && !r_we) ? bus.core_data_in : '0;
  assign w_resp_onehot = NUM_PORTS'(1) << r_idx;

  // Latch the granted request onto the bus and track the bus-cycle count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_idx   <= w_grant_idx;
      r_cyc   <= 1'b1;
      r_we    <= bus.req_we[w_grant_idx];
      r_sel   <= w_sel_arr[w_grant_idx];
      r_addr  <= w_addr_arr[w_grant_idx];
      r_wdata <= w_wdata_arr[w_grant_idx];
      r_cnt   <= '0;
    end else if (w_done) begin
      r_cyc   <= 1'b0;
    end else if (r_state == ST_BUS) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  if (REG_RESP != 0) begin : g_reg_resp
    logic [NUM_PORTS-1:0]  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    // Capture the completion so it is presented during the RESP cycle only.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_resp_valid <= '0;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end else begin
        r_resp_valid <= w_done ? w_resp_onehot : '0;
        r_resp_err   <= w_done && w_err;
        r_resp_rdata <= w_done ? w_rdata : '0;
      end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
  end else begin : g_comb_resp
    assign bus.resp_valid = w_done ? w_resp_onehot : '0;
    assign bus.resp_err   = w_done && w_err;
    assign bus.resp_rdata = w_done ? w_rdata : '0;
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.core_cyc      = r_cyc;
  assign bus.core_stb      = r_cyc;
  assign bus.core_we       = r_we;
  assign bus.core_sel      = r_sel;
  assign bus.core_addr     = r_addr;
  assign bus.core_data_out = r_wdata;

endmodule

// File: tb/tb_wb_core_bridge.sv
// Directed bench: vector table on a combinational-response bridge, plus
// hand sequences for round-robin, registered response and mid-transfer reset.
module tb_wb_core_bridge;

  logic sys_clk = 1'b0;
  logic rst0_n;
  logic rst1_n;

  always #5 sys_clk = ~sys_clk;

  wb_core_bridge_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  wb_core_bridge_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  wb_core_bridge #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_RESP(0), .TIMEOUT_CYCLES(4)
  ) u_dut0 (
    .sys_clk (sys_clk),
    .rst_n   (rst0_n),
    .bus     (bus0)
  );

  wb_core_bridge #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_RESP(1), .TIMEOUT_CYCLES(4)
  ) u_dut1 (
    .sys_clk (sys_clk),
    .rst_n   (rst1_n),
    .bus     (bus1)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;    // stb cycle (1-based) in which the slave acks; 0 = never
    logic [31:0] slv_rdata;
    int          exp_stb;
    logic [1:0]  exp_rv;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int port, input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_cyc, input logic [31:0] slv,
                              input int exp_stb, input logic [1:0] exp_rv,
                              input logic exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.port = port; v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.ack_cyc = ack_cyc; v.slv_rdata = slv; v.exp_stb = exp_stb; v.exp_rv = exp_rv;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // One transaction on bus0; entered and left just after a rising edge.
  task automatic run_txn(input vec_t v, input int id);
    logic [1:0]  exp_ready;
    logic [1:0]  rv;
    logic        err;
    logic [31:0] rdata;
    int          stb_n;
    bit          got;
    exp_ready = 2'(1) << v.port;
    bus0.req_valid = exp_ready;
    if (v.port == 0) begin
      bus0.req_we    = {~v.we, v.we};
      bus0.req_sel   = {~v.sel, v.sel};
      bus0.req_addr  = {~v.addr, v.addr};
      bus0.req_wdata = {~v.wdata, v.wdata};
    end else begin
      bus0.req_we    = {v.we, ~v.we};
      bus0.req_sel   = {v.sel, ~v.sel};
      bus0.req_addr  = {v.addr, ~v.addr};
      bus0.req_wdata = {v.wdata, ~v.wdata};
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge sys_clk);
      if (bus0.req_ready != 2'b00) got = 1'b1;
    end
    check($sformatf("v%0d req_ready", id), 32'(bus0.req_ready), 32'(exp_ready));
    @(posedge sys_clk); #1;
    bus0.req_valid = 2'b00;
    stb_n = 0; got = 1'b0; rv = 2'b00; err = 1'b0; rdata = '0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge sys_clk);
      if (bus0.core_stb) stb_n++;
      if (c == 0) begin
        check($sformatf("v%0d core_cyc", id),  32'(bus0.core_cyc), 32'd1);
        check($sformatf("v%0d core_we", id),   32'(bus0.core_we), 32'(v.we));
        check($sformatf("v%0d core_sel", id),  32'(bus0.core_sel), 32'(v.sel));
        check($sformatf("v%0d core_addr", id), bus0.core_addr, v.addr);
        check($sformatf("v%0d core_dout", id), bus0.core_data_out, v.wdata);
      end
      bus0.core_data_in = v.slv_rdata;
      bus0.core_ack     = (v.ack_cyc != 0) && (stb_n == v.ack_cyc);
      #1;
      if (bus0.resp_valid != 2'b00) begin
        got = 1'b1; rv = bus0.resp_valid; err = bus0.resp_err; rdata = bus0.resp_rdata;
      end
    end
    @(posedge sys_clk); #1;
    bus0.core_ack = 1'b0;
    check($sformatf("v%0d stb_cycles", id), 32'(stb_n), 32'(v.exp_stb));
    check($sformatf("v%0d resp_valid", id), 32'(rv), 32'(v.exp_rv));
    check($sformatf("v%0d resp_err", id), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d resp_rdata", id), rdata, v.exp_rdata);
    @(negedge sys_clk);
    check($sformatf("v%0d cyc_after", id), 32'(bus0.core_cyc), 32'd0);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    logic [1:0] g  [4];
    int         t  [4];
    logic [1:0] rg [4];
    int         rt [4];
    logic [31:0] rd [4];
    int n;
    int m;

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    bus0.req_valid = 2'b11; bus0.req_we = '0; bus0.req_sel = '0; bus0.req_addr = '0;
    bus0.req_wdata = '0; bus0.core_data_in = '0; bus0.core_ack = 1'b0;
    bus1.req_valid = 2'b11; bus1.req_we = '0; bus1.req_sel = '0; bus1.req_addr = '0;
    bus1.req_wdata = '0; bus1.core_data_in = '0; bus1.core_ack = 1'b0;

    vecs[0] = mk(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,          3, 32'hDEAD_BEEF, 3, 2'b01, 1'b0, 32'hDEAD_BEEF);
    vecs[1] = mk(1, 1'b1, 4'h3, 32'h0000_0204, 32'h1234_5678,  1, 32'hFFFF_FFFF, 1, 2'b10, 1'b0, 32'h0);
    vecs[2] = mk(0, 1'b1, 4'hC, 32'h0000_0300, 32'hA0A0_A0A0,  0, 32'h0,         4, 2'b01, 1'b1, 32'h0);
    vecs[3] = mk(1, 1'b0, 4'hF, 32'h0000_0400, 32'h0,          4, 32'hCAFE_F00D, 4, 2'b10, 1'b0, 32'hCAFE_F00D);
    vecs[4] = mk(0, 1'b0, 4'hF, 32'h0000_0500, 32'h0,          1, 32'h1357_9BDF, 1, 2'b01, 1'b0, 32'h1357_9BDF);
    vecs[5] = mk(1, 1'b0, 4'hF, 32'h0000_0600, 32'h0,          0, 32'h1111_1111, 4, 2'b10, 1'b1, 32'h0);

    // Reset state, with requests pending on both ports.
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst req_ready0", 32'(bus0.req_ready), 32'd0);
    check("rst core_cyc0",  32'(bus0.core_cyc), 32'd0);
    check("rst core_stb0",  32'(bus0.core_stb), 32'd0);
    check("rst core_addr0", bus0.core_addr, 32'd0);
    check("rst core_sel0",  32'(bus0.core_sel), 32'd0);
    check("rst resp0",      32'(bus0.resp_valid), 32'd0);
    check("rst req_ready1", 32'(bus1.req_ready), 32'd0);
    check("rst resp1",      32'(bus1.resp_valid), 32'd0);
    check("rst core_cyc1",  32'(bus1.core_cyc), 32'd0);
    bus0.req_valid = 2'b00;
    bus1.req_valid = 2'b00;
    @(posedge sys_clk); #1;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Round-robin with a zero-wait slave: reset so port 0 leads.
    rst0_n = 1'b0;
    @(posedge sys_clk); #1;
    rst0_n = 1'b1;
    bus0.req_valid = 2'b11; bus0.req_we = 2'b00;
    bus0.core_ack = 1'b1; bus0.core_data_in = 32'h0BAD_F00D;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge sys_clk);
      if (bus0.req_ready != 2'b00) begin
        g[n] = bus0.req_ready; t[n] = c; n++;
      end
    end
    @(posedge sys_clk); #1;
    bus0.req_valid = 2'b00;
    @(posedge sys_clk); #1;
    bus0.core_ack = 1'b0;
    check("rr grants seen", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr grant%0d", k), 32'(g[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) check($sformatf("rr spacing%0d", k), 32'(t[k] - t[k-1]), 32'd2);
    end

    // Registered response on bus1: response trails ack by one cycle, 3-cycle spacing.
    bus1.req_valid = 2'b11; bus1.req_we = 2'b00;
    bus1.core_ack = 1'b1; bus1.core_data_in = 32'h5A5A_0001;
    n = 0; m = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      if (bus1.req_ready != 2'b00 && n < 4) begin
        g[n] = bus1.req_ready; t[n] = c; n++;
      end
      if (bus1.resp_valid != 2'b00 && m < 4) begin
        rg[m] = bus1.resp_valid; rt[m] = c; rd[m] = bus1.resp_rdata; m++;
      end
    end
    @(posedge sys_clk); #1;
    bus1.req_valid = 2'b00;
    bus1.core_ack = 1'b0;
    check("rr3 grants seen", 32'(n), 32'd4);
    check("rr3 resps seen", 32'(m), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr3 grant%0d", k), 32'(g[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr3 resp%0d", k), 32'(rg[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr3 resp_lat%0d", k), 32'(rt[k] - t[k]), 32'd2);
      check($sformatf("rr3 rdata%0d", k), rd[k], 32'h5A5A_0001);
      if (k > 0) check($sformatf("rr3 spacing%0d", k), 32'(t[k] - t[k-1]), 32'd3);
    end

    // Reset during BUS on bus0: port 0 in flight, so without a reset port 1 would lead next.
    bus0.req_valid = 2'b01; bus0.req_we = 2'b00; bus0.req_addr = {32'h0, 32'h0000_0700};
    @(negedge sys_clk);
    check("mid req_ready", 32'(bus0.req_ready), 32'd1);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("mid cyc before", 32'(bus0.core_cyc), 32'd1);
    #2;
    rst0_n = 1'b0;
    #1;
    check("mid cyc async", 32'(bus0.core_cyc), 32'd0);
    check("mid stb async", 32'(bus0.core_stb), 32'd0);
    check("mid resp async", 32'(bus0.resp_valid), 32'd0);
    check("mid ready in rst", 32'(bus0.req_ready), 32'd0);
    @(posedge sys_clk); #1;
    check("mid resp after edge", 32'(bus0.resp_valid), 32'd0);
    rst0_n = 1'b1;
    bus0.req_valid = 2'b11;
    @(negedge sys_clk);
    check("post rst grant", 32'(bus0.req_ready), 32'd1);
    @(posedge sys_clk); #1;
    bus0.req_valid = 2'b00;
    @(negedge sys_clk);
    bus0.core_ack = 1'b1;
    @(posedge sys_clk); #1;
    bus0.core_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_core_bridge.md
WB_CORE_BRIDGE -- requirements
Module: wb_core_bridge

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, giving the number of core-side request ports (>=1).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width (multiple of 8).
REQ-004 The block SHALL have parameter REG_RESP, default 0, where 1 registers the core-side response.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus-cycle timeout; 0 disables it.
REQ-006 sys_clk  in  1  single clock, all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  NUM_PORTS  per-port request.
REQ-009 req_ready  out  NUM_PORTS  one-hot accept pulse.
REQ-010 req_we  in  NUM_PORTS  per-port write flag.
REQ-011 req_sel  in  NUM_PORTS*DATA_WIDTH/8  packed byte selects.
REQ-012 req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses.
REQ-013 req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
REQ-014 resp_valid  out  NUM_PORTS  one-hot completion pulse to the granted port.
REQ-015 resp_err  out  1  timeout flag, qualified by resp_valid.
REQ-016 resp_rdata  out  DATA_WIDTH  read data, qualified by resp_valid.
REQ-017 core_cyc / core_stb  out  1 each  Wishbone classic cycle/strobe.
REQ-018 core_we  out  1;  core_sel  out  DATA_WIDTH/8;  core_addr  out  ADDR_WIDTH;  core_data_out  out  DATA_WIDTH.
REQ-019 core_data_in  in  DATA_WIDTH;  core_ack  in  1  Wishbone read data and acknowledge.

Function
REQ-020 The FSM SHALL have states IDLE, BUS, RESP; RESP is used only when REG_RESP=1.
REQ-021 In IDLE with any req_valid high, the arbiter SHALL grant one port and assert req_ready for that port alone in the same cycle; on that edge it SHALL latch the port's we/sel/addr/wdata onto the core_* outputs, set core_cyc=core_stb=1, and enter BUS.
REQ-022 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_PORTS and wraps; after reset last_grant=NUM_PORTS-1, so port 0 has first priority.
REQ-023 In BUS, all core_* outputs SHALL hold stable until completion; req_ready SHALL stay 0.
REQ-024 On the edge where core_ack=1 is sampled in BUS, core_cyc and core_stb SHALL clear.
REQ-025 With REG_RESP=0, resp_valid[grant] SHALL assert combinationally in the ack cycle with resp_rdata=core_data_in for reads, 0 for writes; the next state SHALL be IDLE.
REQ-026 With REG_RESP=1, the response SHALL be registered and presented for exactly one cycle in RESP, after which the FSM returns to IDLE.
REQ-027 A timeout counter SHALL clear on BUS entry and increment each BUS cycle; if it reaches TIMEOUT_CYCLES without ack, the transfer SHALL end as in REQ-024 to REQ-026 with resp_err=1 and resp_rdata=0.
REQ-028 If ack and timeout coincide, ack SHALL win and resp_err SHALL be 0.
REQ-029 Only one transfer SHALL be outstanding; with a zero-wait slave, throughput SHALL be 1 transfer per 2 cycles (REG_RESP=0) or per 3 cycles (REG_RESP=1).
REQ-030 req_valid dropping before grant SHALL have no effect; core_ack outside BUS SHALL be ignored.

Reset
REQ-031 While rst_n=0, all outputs, core_* registers, the counter and response registers SHALL be 0, the state SHALL be IDLE and last_grant SHALL be NUM_PORTS-1; a reset mid-transfer SHALL drop cyc/stb immediately and emit no response.

Structure
REQ-032 Package wb_core_bridge_pkg SHALL hold the state enum and a sel-width constant function; round-robin grant logic SHALL be sub-module wb_rr_arbiter.

Verification
REQ-033 Port0 read, addr 0x0000_0100, slave acks in the 3rd stb cycle with 0xDEADBEEF -> cyc high 3 cycles, resp_valid=01 for 1 cycle, rdata=0xDEADBEEF, err=0.
REQ-034 Both ports hold req_valid, zero-wait slave -> grants alternate 0,1,0,1, each accepted 2 cycles apart.
REQ-035 Port1 write, sel=0011, wdata=0x1234_5678 -> core_we=1, core_sel=0011, core_data_out=0x12345678, resp_valid=10, resp_rdata=0.
REQ-036 TIMEOUT_CYCLES=4, slave never acks -> stb high exactly 4 cycles, resp_err=1, resp_rdata=0, next request then serviced normally.
REQ-037 REG_RESP=1, zero-wait slave -> resp_valid one cycle after ack; back-to-back accepts 3 cycles apart.
REQ-038 rst_n low during BUS -> cyc/stb low without waiting for a clock edge, no resp_valid; after release, port 0 is granted first.
